// File: rtl/fir_seq_mc.sv
// fir_seq_mc: multi-channel, time-multiplexed FIR filter.
//
// One multiplier-accumulator is shared by all channels and processes one
// tap per clock. Each channel owns an N-deep delay line, all channels share
// one coefficient set that is captured when a sample is accepted, and results
// are rounded (half-up) and saturated, with a flag when clipping occurred.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   packed_coeffs N signed coefficients, c_k at [k*COEFF_WIDTH +: COEFF_WIDTH]
//   flush         synchronous clear of all delay lines, aborts any computation
//   in_valid      sample offered
//   in_ready      block can accept a sample
//   in_channel    channel of the offered sample
//   x             signed input sample
//   out_valid     one-cycle result strobe
//   out_channel   channel of the result
//   y             signed rounded/saturated result
//   out_sat       y was clipped
module fir_seq_mc #(
    parameter int N            = 4,
    parameter int CHANNELS     = 1,
    parameter int INPUT_WIDTH  = 12,
    parameter int COEFF_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int FRAC_BITS    = 0,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int ACC_W       = INPUT_WIDTH + COEFF_WIDTH + $clog2(N)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N*COEFF_WIDTH-1:0]       packed_coeffs,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CH_W-1:0]                in_channel,
    input  logic signed [INPUT_WIDTH-1:0]  x,
    output logic                           out_valid,
    output logic [CH_W-1:0]                out_channel,
    output logic signed [OUTPUT_WIDTH-1:0] y,
    output logic                           out_sat
);

    localparam int CNT_W  = $clog2(N);
    localparam int PROD_W = INPUT_WIDTH + COEFF_WIDTH;
    // Working width for rounding and clamping: wide enough for the rounding
    // carry and for comparison against the output range, plus a sign bit.
    localparam int SW     = ((ACC_W + 1 > OUTPUT_WIDTH) ? ACC_W + 1 : OUTPUT_WIDTH) + 1;
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [SW-1:0] RND     = (FRAC_BITS > 0) ? (SW'(1) <<< RND_SH) : '0;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, MAC} state_e;

    state_e                           state_q, state_d;
    logic signed [INPUT_WIDTH-1:0]    delayLine_q [CHANNELS][N];
    logic [N*COEFF_WIDTH-1:0]         coeffReg_q;
    logic [CH_W-1:0]                  chan_q;
    logic [CNT_W-1:0]                 tapCnt_q;
    logic signed [ACC_W-1:0]          acc_q, acc_d;
    logic                             outValid_q;
    logic                             outSat_q;
    logic [CH_W-1:0]                  outChannel_q;
    logic signed [OUTPUT_WIDTH-1:0]   y_q;

    logic                             handshake;
    logic                             chanOk;
    logic                             lastTap;
    logic signed [INPUT_WIDTH-1:0]    tapSel;
    logic signed [COEFF_WIDTH-1:0]    coefSel;
    logic signed [PROD_W-1:0]         prod;
    logic signed [SW-1:0]             rounded;
    logic                             satHi, satLo;
    logic signed [OUTPUT_WIDTH-1:0]   y_d;

    assign handshake = in_valid && in_ready;
    // Out-of-range channels still complete the handshake but are dropped.
    assign chanOk    = ({1'b0, in_channel} < (CH_W+1)'(CHANNELS));
    assign lastTap   = (state_q == MAC) && (tapCnt_q == CNT_W'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (handshake && chanOk) state_d = MAC;
                MAC:     if (lastTap)             state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        in_ready = (state_q == IDLE) && !flush;
    end

    // Select the current tap of the active channel and its coefficient.
    always_comb begin
        tapSel  = '0;
        coefSel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < N; k++) begin
                if (chan_q == CH_W'(c) && tapCnt_q == CNT_W'(k)) begin
                    tapSel = delayLine_q[c][k];
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (tapCnt_q == CNT_W'(k)) begin
                coefSel = coeffReg_q[k*COEFF_WIDTH +: COEFF_WIDTH];
            end
        end
    end

    // Accumulate, then round half-up and clamp the final sum.
    always_comb begin
        prod    = coefSel * tapSel;
        acc_d   = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        rounded = ($signed({{(SW-ACC_W){acc_d[ACC_W-1]}}, acc_d}) + RND) >>> FRAC_BITS;
        satHi   = rounded > SAT_MAX;
        satLo   = rounded < SAT_MIN;
        if (satHi) begin
            y_d = SAT_MAX[OUTPUT_WIDTH-1:0];
        end else if (satLo) begin
            y_d = SAT_MIN[OUTPUT_WIDTH-1:0];
        end else begin
            y_d = rounded[OUTPUT_WIDTH-1:0];
        end
    end

    // Datapath: delay lines, captured coefficients, MAC and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < N; k++) begin
                    delayLine_q[c][k] <= '0;
                end
            end
            coeffReg_q   <= '0;
            chan_q       <= '0;
            tapCnt_q     <= '0;
            acc_q        <= '0;
            outValid_q   <= 1'b0;
            outSat_q     <= 1'b0;
            outChannel_q <= '0;
            y_q          <= '0;
        end else begin
            outValid_q <= 1'b0;
            if (flush) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int k = 0; k < N; k++) begin
                        delayLine_q[c][k] <= '0;
                    end
                end
                acc_q    <= '0;
                tapCnt_q <= '0;
            end else if (handshake && chanOk) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (in_channel == CH_W'(c)) begin
                        delayLine_q[c][0] <= x;
                        for (int k = 1; k < N; k++) begin
                            delayLine_q[c][k] <= delayLine_q[c][k-1];
                        end
                    end
                end
                coeffReg_q <= packed_coeffs;
                chan_q     <= in_channel;
                acc_q      <= '0;
                tapCnt_q   <= '0;
            end else if (state_q == MAC) begin
                acc_q    <= acc_d;
                tapCnt_q <= tapCnt_q + 1'b1;
                if (lastTap) begin
                    outValid_q   <= 1'b1;
                    outSat_q     <= satHi || satLo;
                    outChannel_q <= chan_q;
                    y_q          <= y_d;
                end
            end
        end
    end

    assign out_valid   = outValid_q;
    assign out_channel = outChannel_q;
    assign y           = y_q;
    assign out_sat     = outSat_q;

endmodule

// File: tb/tb_fir_seq_mc.sv
// tb_fir_seq_mc: directed bench for fir_seq_mc.
//
// Three instances share clock, reset, flush, sample, channel and coefficient
// inputs, each with its own in_valid:
//   u0  CHANNELS=3, default widths  (sequence, isolation, capture, abort)
//   u1  OUTPUT_WIDTH=8              (saturation)
//   u2  FRAC_BITS=2                 (rounding)
module tb_fir_seq_mc;

    typedef struct {
        int          sel;
        int          ch;
        int          xs;
        logic [31:0] coeffs;
        int          expCh;
        int          expY;
        int          expSat;
    } vec_t;

    // c_3..c_0 = {4, 3, -1, -2}
    localparam logic [31:0] COEF_A    = 32'h0403FFFE;
    localparam logic [31:0] COEF_ZERO = 32'h00000000;
    localparam logic [31:0] COEF_SAT  = 32'h00000004;
    localparam logic [31:0] COEF_RND  = 32'h00000001;
    localparam int          LAT       = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic [31:0]        coeffs;
    logic [1:0]         inChannel;
    logic signed [11:0] x;
    logic               inValid0, inValid1, inValid2;
    logic               inReady0, inReady1, inReady2;
    logic               outValid0, outValid1, outValid2;
    logic [1:0]         outCh0;
    logic [0:0]         outCh1, outCh2;
    logic signed [15:0] y0;
    logic signed [7:0]  y1;
    logic signed [15:0] y2;
    logic               outSat0, outSat1, outSat2;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[15];

    always #5 clk = ~clk;

    fir_seq_mc #(.N(4), .CHANNELS(3)) u0 (
        .clk(clk), .rst_n(rst_n), .packed_coeffs(coeffs), .flush(flush),
        .in_valid(inValid0), .in_ready(inReady0), .in_channel(inChannel), .x(x),
        .out_valid(outValid0), .out_channel(outCh0), .y(y0), .out_sat(outSat0)
    );

    fir_seq_mc #(.N(4), .CHANNELS(1), .OUTPUT_WIDTH(8)) u1 (
        .clk(clk), .rst_n(rst_n), .packed_coeffs(coeffs), .flush(flush),
        .in_valid(inValid1), .in_ready(inReady1), .in_channel(inChannel[0:0]), .x(x),
        .out_valid(outValid1), .out_channel(outCh1), .y(y1), .out_sat(outSat1)
    );

    fir_seq_mc #(.N(4), .CHANNELS(1), .FRAC_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .packed_coeffs(coeffs), .flush(flush),
        .in_valid(inValid2), .in_ready(inReady2), .in_channel(inChannel[0:0]), .x(x),
        .out_valid(outValid2), .out_channel(outCh2), .y(y2), .out_sat(outSat2)
    );

    function automatic logic readyOf(input int sel);
        case (sel)
            0:       return inReady0;
            1:       return inReady1;
            default: return inReady2;
        endcase
    endfunction

    function automatic logic validOf(input int sel);
        case (sel)
            0:       return outValid0;
            1:       return outValid1;
            default: return outValid2;
        endcase
    endfunction

    function automatic int yOf(input int sel);
        case (sel)
            0:       return int'(y0);
            1:       return int'(y1);
            default: return int'(y2);
        endcase
    endfunction

    function automatic int satOf(input int sel);
        case (sel)
            0:       return int'(outSat0);
            1:       return int'(outSat1);
            default: return int'(outSat2);
        endcase
    endfunction

    function automatic int chOf(input int sel);
        case (sel)
            0:       return int'(outCh0);
            1:       return int'(outCh1);
            default: return int'(outCh2);
        endcase
    endfunction

    task automatic setValid(input int sel, input logic v);
        case (sel)
            0:       inValid0 = v;
            1:       inValid1 = v;
            default: inValid2 = v;
        endcase
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait for in_ready, then hold in_valid for one rising edge.
    task automatic applyStimulus(input int sel, input int ch, input int xs);
        int waited = 0;
        @(negedge clk);
        while (!readyOf(sel) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready timeout on u%0d: got 0, expected 1", sel);
            return;
        end
        inChannel = 2'(ch);
        x         = 12'(xs);
        setValid(sel, 1'b1);
        @(posedge clk);
        #1;
        setValid(sel, 1'b0);
    endtask

    // Count rising edges until out_valid, then compare the result fields.
    task automatic checkOutput(input int sel, input string tag, input int expCh,
                               input int expY, input int expSat, input int expLat);
        int  edges = 0;
        bit  seen  = 0;
        while (edges <= 20) begin
            @(negedge clk);
            if (validOf(sel)) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            edges++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s out_valid timeout: got 0, expected 1", tag);
            return;
        end
        checkVal({tag, " latency"}, edges, expLat);
        checkVal({tag, " y"}, yOf(sel), expY);
        checkVal({tag, " out_sat"}, satOf(sel), expSat);
        checkVal({tag, " out_channel"}, chOf(sel), expCh);
        @(negedge clk);
        checkVal({tag, " strobe width"}, int'(validOf(sel)), 0);
    endtask

    task automatic noOutputFor(input int sel, input int cycles, input string tag);
        int seenCnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (validOf(sel)) seenCnt++;
        end
        checkVal(tag, seenCnt, 0);
    endtask

    task automatic pulseFlush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        coeffs    = COEF_A;
        inChannel = '0;
        x         = '0;
        inValid0  = 1'b0;
        inValid1  = 1'b0;
        inValid2  = 1'b0;

        vecs[0]  = '{0, 0,    -3, COEF_A,   0,    6, 0};
        vecs[1]  = '{0, 0,     1, COEF_A,   0,    1, 0};
        vecs[2]  = '{0, 0,     0, COEF_A,   0,  -10, 0};
        vecs[3]  = '{0, 0,    -2, COEF_A,   0,   -5, 0};
        vecs[4]  = '{1, 0,  2047, COEF_SAT, 0,  127, 1};
        vecs[5]  = '{1, 0, -2048, COEF_SAT, 0, -128, 1};
        vecs[6]  = '{1, 0,    10, COEF_SAT, 0,   40, 0};
        vecs[7]  = '{1, 0,    31, COEF_SAT, 0,  124, 0};
        vecs[8]  = '{1, 0,    32, COEF_SAT, 0,  127, 1};
        vecs[9]  = '{1, 0,   -32, COEF_SAT, 0, -128, 0};
        vecs[10] = '{2, 0,     6, COEF_RND, 0,    2, 0};
        vecs[11] = '{2, 0,    -6, COEF_RND, 0,   -1, 0};
        vecs[12] = '{2, 0,     5, COEF_RND, 0,    1, 0};
        vecs[13] = '{2, 0,    -7, COEF_RND, 0,   -2, 0};
        vecs[14] = '{2, 0,    -5, COEF_RND, 0,   -1, 0};

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        checkVal("reset in_ready", int'(inReady0), 1);
        checkVal("reset out_valid", int'(outValid0), 0);
        checkVal("reset y", yOf(0), 0);
        checkVal("reset out_channel", chOf(0), 0);
        checkVal("reset out_sat", satOf(0), 0);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            coeffs = vecs[i].coeffs;
            applyStimulus(vecs[i].sel, vecs[i].ch, vecs[i].xs);
            checkOutput(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].expCh,
                        vecs[i].expY, vecs[i].expSat, LAT);
        end

        // Channel isolation from a cleared history.
        coeffs = COEF_A;
        pulseFlush();
        applyStimulus(0, 0, -3);
        checkOutput(0, "iso ch0 a", 0, 6, 0, LAT);
        applyStimulus(0, 1, 5);
        checkOutput(0, "iso ch1 a", 1, -10, 0, LAT);
        applyStimulus(0, 0, 1);
        checkOutput(0, "iso ch0 b", 0, 1, 0, LAT);
        applyStimulus(0, 1, 0);
        checkOutput(0, "iso ch1 b", 1, -5, 0, LAT);

        // Coefficients changed mid-MAC only affect the next sample.
        pulseFlush();
        applyStimulus(0, 0, -3);
        @(negedge clk);
        coeffs = COEF_ZERO;
        checkOutput(0, "capture old", 0, 6, 0, LAT - 1);
        applyStimulus(0, 0, 1);
        checkOutput(0, "capture new", 0, 0, 0, LAT);
        coeffs = COEF_A;

        // Flush mid-MAC aborts the result and clears the history.
        applyStimulus(0, 0, 7);
        @(negedge clk);
        checkVal("busy in_ready", int'(inReady0), 0);
        pulseFlush();
        noOutputFor(0, 8, "flush abort out_valid count");
        applyStimulus(0, 0, -3);
        checkOutput(0, "after flush", 0, 6, 0, LAT);

        // Out-of-range channel: accepted, dropped, no delay line change.
        applyStimulus(0, 3, 100);
        checkVal("bad channel stays idle", int'(inReady0), 1);
        noOutputFor(0, 8, "bad channel out_valid count");
        applyStimulus(0, 0, 1);
        checkOutput(0, "after bad channel", 0, 1, 0, LAT);
        applyStimulus(0, 1, 4);
        checkOutput(0, "ch1 fresh", 1, -8, 0, LAT);

        // Reset mid-MAC returns outputs to reset values at once.
        applyStimulus(0, 0, 5);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("mid reset in_ready", int'(inReady0), 1);
        checkVal("mid reset out_valid", int'(outValid0), 0);
        checkVal("mid reset y", yOf(0), 0);
        checkVal("mid reset out_channel", chOf(0), 0);
        checkVal("mid reset out_sat", satOf(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        noOutputFor(0, 6, "mid reset out_valid count");
        applyStimulus(0, 0, -3);
        checkOutput(0, "after reset", 0, 6, 0, LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_seq_mc.md
# fir_seq_mc

Multi-channel, time-multiplexed FIR filter for the analogue front-end sample path. It serves CHANNELS independent streams with a single multiplier-accumulator, one tap per clock. Each channel has its own N-deep delay line. All channels share one run-time coefficient set. Outputs are rounded and saturated, with a saturation flag per result. It sits between the ADC capture logic and decimation/trigger stages, and supersedes the single-channel, fully parallel reference FIR.

## Interface
- N, 4: number of taps (≥2).
- CHANNELS, 1: independent channels (≥1); CH_W = max(1, clog2(CHANNELS)).
- INPUT_WIDTH, 12: signed sample width.
- COEFF_WIDTH, 8: signed coefficient width.
- OUTPUT_WIDTH, 16: signed result width.
- FRAC_BITS, 0: coefficient fractional bits, removed by rounding before saturation.
- ACC_W (derived): INPUT_WIDTH + COEFF_WIDTH + clog2(N), the full-precision accumulator width.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- packed_coeffs, in, N*COEFF_WIDTH: signed c_k = packed_coeffs[k*COEFF_WIDTH +: COEFF_WIDTH]; c_0 multiplies the newest sample.
- flush, in, 1: synchronous clear of all delay lines plus abort of any computation.
- in_valid, in, 1: sample offered.
- in_ready, out, 1: block can accept a sample.
- in_channel, in, CH_W: channel of the offered sample.
- x, in, INPUT_WIDTH: signed sample.
- out_valid, out, 1: one-cycle result strobe.
- out_channel, out, CH_W: channel of the result.
- y, out, OUTPUT_WIDTH: signed result.
- out_sat, out, 1: y was clipped; valid with out_valid.

## Operation
- Function per channel: y[n] = sat(round(Σ_{k=0}^{N-1} c_k·x[n−k])). Delay lines start at zero.
- round: (acc + 2^(FRAC_BITS−1)) >>> FRAC_BITS, i.e. round-half-up. With FRAC_BITS=0 the accumulator passes through unchanged.
- sat: clamp to [−2^(OUTPUT_WIDTH−1), 2^(OUTPUT_WIDTH−1)−1]. out_sat=1 iff clamped.
- If OUTPUT_WIDTH exceeds the rounded width, the result is sign-extended.
- Accumulation is exact in ACC_W bits; there is no intermediate overflow.

FSM states are IDLE and MAC.
- IDLE: in_ready = !flush.
- IDLE → MAC on a handshake (in_valid && in_ready). On that edge:
  - the channel's delay line shifts, with x entering tap 0;
  - packed_coeffs is captured into an internal register;
  - in_channel is latched;
  - the accumulator is cleared and the tap counter is set to 0.
- MAC: one product c_k·x[n−k] is added per cycle, k = 0..N−1. in_ready = 0.
- MAC → IDLE on the last tap (k = N−1). On that edge, y, out_sat, out_channel and out_valid=1 are registered.
- Coefficient changes during MAC have no effect on the result in flight. They apply from the next handshake.
- in_channel ≥ CHANNELS: the handshake completes, the sample is discarded, no delay line changes, no out_valid is produced, and the FSM stays in IDLE.
- Only the addressed channel's delay line moves. Other channels are untouched.

flush, in any state:
- zeroes every delay line;
- forces IDLE and clears the accumulator;
- suppresses out_valid on that edge;
- drops a same-cycle sample, because in_ready is already low.

## Timing
- Reset values: in_ready=1, out_valid=0, out_channel=0, y=0, out_sat=0, state=IDLE. All delay lines, the accumulator, the coefficient register and the tap counter are 0.
- Latency: a handshake at edge E0 gives out_valid high in the cycle after edge E_N, i.e. N cycles edge-to-edge.
- Throughput: one sample per N+1 cycles. in_ready returns high in the same cycle out_valid is high, so back-to-back acceptance is possible.
- out_valid lasts exactly one cycle. There is no output backpressure.
- y, out_sat and out_channel hold their values until the next result.
- Reset asserted mid-MAC: all state returns immediately to the reset values and no result is emitted.

## Test plan
- **Impulse/sequence, defaults.** Coeffs {4,3,−1,−2} (c_3..c_0). After reset, channel 0 receives −3, 1, 0, −2, each sample waiting for in_ready. Required y = 6, 1, −10, −5. out_sat=0, and each out_valid arrives 4 cycles after its handshake.
- **Channel isolation.** CHANNELS=2, same coeffs. Send ch0:−3, ch1:5, ch0:1, ch1:0. Required (ch0, 6), (ch1, −10), (ch0, 1), (ch1, −5).
- **Saturation.** OUTPUT_WIDTH=8, c_0=4, other coeffs 0. x=2047 → y=127, out_sat=1. x=−2048 → y=−128, out_sat=1. x=10 → y=40, out_sat=0.
- **Rounding.** FRAC_BITS=2, c_0=1, other coeffs 0. x=6 → 2; x=−6 → −1; x=5 → 1.
- **Coefficient capture.** Change packed_coeffs to all-zero during MAC. The in-flight result uses the old coeffs; the next sample yields 0.
- **Flush/reset abort.**
  - Pulse flush mid-MAC: no out_valid. The next sample x=−3 yields 6, confirming the history was cleared.
  - Assert rst_n=0 mid-MAC: outputs return to their reset values immediately.
  - Send in_channel=CHANNELS: the handshake completes with no output.
